// File: rtl/dmem_arbiter_if.sv
// Bundle of the LS port, SD burst port and dmem-side signals around dmem_arbiter.
// The arbiter takes the slave view; the requesters and dmem take the master view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  // load/store port from the Memory stage
  logic              ls_req;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_data;
  logic              ls_R_nW;
  logic              ls_stall;

  // SDRAM controller burst port
  logic              sd_request;
  logic              sd_granted;
  logic              sd_valid;
  logic [ADDR_W-1:0] sd_addr;
  logic [DATA_W-1:0] sd_data;
  logic              sd_R_nW;
  logic              sd_done;

  // dmem side and status
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_data;
  logic              dm_R_nW;
  logic              d_sb;
  logic              busy;

  modport slave (
    input  ls_req, ls_addr, ls_data, ls_R_nW,
    input  sd_request, sd_valid, sd_addr, sd_data, sd_R_nW, sd_done,
    output ls_stall, sd_granted, dm_addr, dm_data, dm_R_nW, d_sb, busy
  );

  modport master (
    output ls_req, ls_addr, ls_data, ls_R_nW,
    output sd_request, sd_valid, sd_addr, sd_data, sd_R_nW, sd_done,
    input  ls_stall, sd_granted, dm_addr, dm_data, dm_R_nW, d_sb, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Ownership FSM sharing single-port dmem between the LS port and SDRAM bursts.
// Define DMEM_ARB_FAIR_EN to add a one-cycle LS yield every MAX_BURST SD beats.
module dmem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic           ref_clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  if (MAX_BURST < 1) begin : g_bad_max_burst
    $error("dmem_arbiter: MAX_BURST must be >= 1");
  end

`ifdef DMEM_ARB_FAIR_EN
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, YIELD = 2'd2} state_t;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;
`endif

  state_t state, state_nxt;
  logic   granted_q, d_sb_q;

`ifdef DMEM_ARB_FAIR_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  logic [CNT_W-1:0] cnt, cnt_inc;

  // Count includes the beat presented this cycle, so the yield follows beat MAX_BURST.
  always_comb begin
    cnt_inc = cnt;
    if (bus.sd_valid && cnt != MAX_CNT) cnt_inc = cnt + 1'b1;
  end

  always_ff @(posedge ref_clk) begin
    if (rst)                cnt <= '0;
    else if (state == GRANT) cnt <= cnt_inc;
    else                    cnt <= '0;
  end
`endif

  always_ff @(posedge ref_clk) begin
    if (rst) begin
      state     <= IDLE;
      granted_q <= 1'b0;
      d_sb_q    <= 1'b1;
    end else begin
      state     <= state_nxt;
      granted_q <= (state_nxt == GRANT);
      d_sb_q    <= (state_nxt != GRANT);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.sd_request) state_nxt = GRANT;
      GRANT: begin
        if ((bus.sd_valid && bus.sd_done) || !bus.sd_request) state_nxt = IDLE;
`ifdef DMEM_ARB_FAIR_EN
        else if (bus.ls_req && cnt_inc == MAX_CNT) state_nxt = YIELD;
`endif
      end
`ifdef DMEM_ARB_FAIR_EN
      YIELD: state_nxt = bus.sd_request ? GRANT : IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // dmem mux follows the registered owner; an unqualified owner never writes.
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] data_mux;
  logic              rnw_mux;

  always_comb begin
    addr_mux = bus.ls_addr;
    data_mux = bus.ls_data;
    rnw_mux  = 1'b1;
    if (d_sb_q) begin
      if (bus.ls_req) rnw_mux = bus.ls_R_nW;
    end else begin
      addr_mux = bus.sd_addr;
      data_mux = bus.sd_data;
      if (bus.sd_valid) rnw_mux = bus.sd_R_nW;
    end
  end

  assign bus.dm_addr    = addr_mux;
  assign bus.dm_data    = data_mux;
  assign bus.dm_R_nW    = rnw_mux;
  assign bus.d_sb       = d_sb_q;
  assign bus.sd_granted = granted_q;
  assign bus.ls_stall   = granted_q & bus.ls_req;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, LS pass-through, bursts, stall, fairness, abort.
module tb_dmem_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int MB = 4;

  logic ref_clk = 1'b0;
  logic rst     = 1'b1;
  always #5 ref_clk = ~ref_clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .ref_clk (ref_clk),
    .rst     (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ref_clk);
    #1;
  endtask

`ifdef DMEM_ARB_FAIR_EN
  localparam int NCYC = 13;
  logic [NCYC-1:0] exp_g = 13'b0_1101_1110_1111;
`else
  localparam int NCYC = 11;
  logic [NCYC-1:0] exp_g = 11'b011_1111_1111;
`endif

  initial begin
    int b;
    bus.ls_req = 0; bus.ls_addr = 0; bus.ls_data = 0; bus.ls_R_nW = 1;
    bus.sd_request = 0; bus.sd_valid = 0; bus.sd_addr = 0; bus.sd_data = 0;
    bus.sd_R_nW = 1; bus.sd_done = 0;

    // reset state
    tick(); tick();
    rst = 0;
    #1;
    chk("rst_granted", bus.sd_granted, 0);
    chk("rst_d_sb",    bus.d_sb, 1);
    chk("rst_busy",    bus.busy, 0);
    chk("rst_stall",   bus.ls_stall, 0);
    chk("rst_rnw",     bus.dm_R_nW, 1);

    // zero-latency LS write in IDLE
    bus.ls_req = 1; bus.ls_R_nW = 0; bus.ls_addr = 16'h0010; bus.ls_data = 8'hA5;
    #1;
    chk("ls_wr_rnw",   bus.dm_R_nW, 0);
    chk("ls_wr_addr",  bus.dm_addr, 16'h0010);
    chk("ls_wr_data",  bus.dm_data, 8'hA5);
    chk("ls_wr_stall", bus.ls_stall, 0);

    // sd_request with LS read together: LS unstalled, grant next cycle, 4 write beats
    tick();
    bus.ls_req = 1; bus.ls_R_nW = 1; bus.ls_addr = 16'h0020; bus.sd_request = 1;
    #1;
    chk("req_ls_stall", bus.ls_stall, 0);
    chk("req_ls_addr",  bus.dm_addr, 16'h0020);
    chk("req_ls_rnw",   bus.dm_R_nW, 1);
    chk("req_granted",  bus.sd_granted, 0);
    tick();
    bus.ls_req = 0;
    for (int i = 0; i < 4; i++) begin
      bus.sd_valid = 1; bus.sd_R_nW = 0; bus.sd_addr = 16'(16'h0100 + i);
      bus.sd_data = 8'(8'h10 + i); bus.sd_done = (i == 3);
      #1;
      chk("b1_granted", bus.sd_granted, 1);
      chk("b1_d_sb",    bus.d_sb, 0);
      chk("b1_busy",    bus.busy, 1);
      chk("b1_addr",    bus.dm_addr, 32'(16'h0100 + i));
      chk("b1_data",    bus.dm_data, 32'(8'h10 + i));
      chk("b1_rnw",     bus.dm_R_nW, 0);
      tick();
    end
    bus.sd_valid = 0; bus.sd_done = 0; bus.sd_request = 0;
    #1;
    chk("b1_rel_granted", bus.sd_granted, 0);
    chk("b1_rel_d_sb",    bus.d_sb, 1);

    // LS held during a 4-beat burst: stalled every GRANT cycle, done on release
    tick();
    bus.sd_request = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.ls_req = 1; bus.ls_R_nW = 0; bus.ls_addr = 16'h0030; bus.ls_data = 8'h5A;
      bus.sd_valid = 1; bus.sd_R_nW = 0; bus.sd_addr = 16'(16'h0200 + i);
      bus.sd_data = 8'(i); bus.sd_done = (i == 3);
      #1;
      chk("b2_stall", bus.ls_stall, 1);
      chk("b2_addr",  bus.dm_addr, 32'(16'h0200 + i));
      tick();
    end
    bus.sd_valid = 0; bus.sd_done = 0; bus.sd_request = 0;
    #1;
    chk("b2_rel_stall", bus.ls_stall, 0);
    chk("b2_rel_addr",  bus.dm_addr, 16'h0030);
    chk("b2_rel_data",  bus.dm_data, 8'h5A);
    chk("b2_rel_rnw",   bus.dm_R_nW, 0);

    // 10-beat burst with LS held; SD presents beats only while granted
    tick();
    bus.ls_req = 0; bus.sd_request = 1;
    tick();
    b = 0;
    for (int c = 0; c < NCYC; c++) begin
      bus.ls_req = 1; bus.ls_R_nW = 0; bus.ls_addr = 16'h0040; bus.ls_data = 8'h3C;
      if (b == 10) bus.sd_request = 0;
      if (bus.sd_granted && b < 10) begin
        bus.sd_valid = 1; bus.sd_R_nW = 0; bus.sd_addr = 16'(16'h0400 + b);
        bus.sd_data = 8'(b); bus.sd_done = (b == 9);
      end else begin
        bus.sd_valid = 0; bus.sd_done = 0;
      end
      #1;
      chk("f_granted", bus.sd_granted, 32'(exp_g[c]));
      chk("f_stall",   bus.ls_stall, 32'(exp_g[c]));
      chk("f_rnw",     bus.dm_R_nW, 0);
      if (bus.sd_valid) begin
        chk("f_sd_addr", bus.dm_addr, 32'(16'h0400 + b));
        b++;
      end else begin
        chk("f_ls_addr", bus.dm_addr, 16'h0040);
        chk("f_ls_data", bus.dm_data, 8'h3C);
      end
      tick();
    end
    chk("f_beats", 32'(b), 10);
    bus.ls_req = 0; bus.sd_valid = 0; bus.sd_done = 0; bus.sd_request = 0;
    #1;
    chk("f_end_busy", bus.busy, 0);

    // abort: request drops after beat 2 without sd_done
    tick();
    bus.sd_request = 1;
    tick();
    for (int i = 0; i < 2; i++) begin
      bus.sd_valid = 1; bus.sd_R_nW = 0; bus.sd_addr = 16'(16'h0500 + i);
      tick();
    end
    bus.sd_valid = 0; bus.sd_request = 0;
    #1;
    chk("ab_drop_granted", bus.sd_granted, 1);
    tick();
    chk("ab_granted", bus.sd_granted, 0);
    chk("ab_busy",    bus.busy, 0);
    chk("ab_d_sb",    bus.d_sb, 1);

    // sd_valid while not granted: no write, no grant
    bus.sd_valid = 1; bus.sd_R_nW = 0; bus.sd_addr = 16'h0300; bus.ls_req = 0;
    #1;
    chk("ng_rnw",  bus.dm_R_nW, 1);
    chk("ng_d_sb", bus.d_sb, 1);
    tick();
    chk("ng_granted", bus.sd_granted, 0);
    bus.sd_valid = 0;

    // reset mid-burst
    bus.sd_request = 1;
    tick();
    bus.sd_valid = 1; bus.sd_R_nW = 0; bus.sd_addr = 16'h0600;
    tick();
    rst = 1;
    #1;
    chk("mr_pre_granted", bus.sd_granted, 1);
    tick();
    rst = 0; bus.sd_valid = 0; bus.sd_request = 0; bus.ls_req = 0;
    #1;
    chk("mr_granted", bus.sd_granted, 0);
    chk("mr_d_sb",    bus.d_sb, 1);
    chk("mr_busy",    bus.busy, 0);
    chk("mr_stall",   bus.ls_stall, 0);
    chk("mr_rnw",     bus.dm_R_nW, 1);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Sequences and shares the single-port data memory (dmem) between two requesters: the pipeline load/store port (LS) and the SDRAM controller's burst fill/flush port (SD).
- Replaces the free-running `d_sb` mux select in the Memory stage with a registered ownership FSM, a grant handshake toward the SDRAM controller, and a stall toward the pipeline.
- Sits between the Memory-stage LS signals, the SDRAM controller, and dmem; drives dmem's address, data and R_nW directly.

## Interface
- ADDR_W, 16, dmem address width
- DATA_W, 8, dmem data width
- MAX_BURST, 16, SD beats allowed before a fairness yield (only used when the fairness feature is compiled in); must be ≥1
- ref_clk  in  1  sole clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- ls_req  in  1  LS wants a dmem access this cycle
- ls_addr  in  ADDR_W  LS address
- ls_data  in  DATA_W  LS store data
- ls_R_nW  in  1  LS direction: 1 = read, 0 = write
- ls_stall  out  1  LS access not performed this cycle; pipeline holds its request
- sd_request  in  1  SD wants dmem ownership for a burst; held high until the burst ends
- sd_granted  out  1  registered; SD owns dmem this cycle
- sd_valid  in  1  SD beat present; legal only while sd_granted=1
- sd_addr  in  ADDR_W  SD beat address
- sd_data  in  DATA_W  SD beat write data
- sd_R_nW  in  1  SD beat direction
- sd_done  in  1  qualifies the last beat (sampled only with sd_valid=1)
- dm_addr  out  ADDR_W  to dmem
- dm_data  out  DATA_W  to dmem
- dm_R_nW  out  1  to dmem; 1 whenever no write is performed
- d_sb  out  1  registered owner flag: 1 = LS, 0 = SD
- busy  out  1  1 in any state other than IDLE

## Operation

### States
- IDLE: `d_sb`=1, `sd_granted`=0.
  - Goes to GRANT when `sd_request`=1. This happens even if `ls_req`=1 in the same cycle; that LS access still completes, unstalled.
- GRANT: `d_sb`=0, `sd_granted`=1.
  - `ls_stall`=`ls_req`.
  - Beat counter increments on each `sd_valid`.
  - Goes to IDLE on `sd_valid&sd_done`, or when `sd_request` drops (abort).
  - Goes to YIELD when the fairness feature is enabled, the counter has reached MAX_BURST, `ls_req`=1, and the current beat is not the last.
- YIELD (fairness only): `d_sb`=1, `sd_granted`=0, `ls_stall`=0.
  - Lasts exactly one cycle and serves one LS access.
  - Counter clears; returns to GRANT, or to IDLE if `sd_request`=0.

### Datapath and counter
- Datapath mux:
  - `d_sb`=1: `dm_*` = `ls_*`.
  - `d_sb`=0: `dm_*` = `sd_*`.
  - `dm_R_nW` is forced to 1 when the owner's qualifier is low: `ls_req`=0 under LS ownership, or `sd_valid`=0 under SD ownership. This prevents spurious writes.
- Beat counter is $clog2(MAX_BURST+1) bits and saturates at MAX_BURST.
- `sd_valid` outside GRANT is ignored: no dmem write, no count.

## Timing
- Reset (`rst`=1 at a clock edge): state IDLE, counter 0, `sd_granted`=0, `d_sb`=1, `busy`=0.
  - `ls_stall`=0 and `dm_R_nW`=1 while `ls_req`=0.
  - Applies mid-burst: the grant drops in the cycle after reset is sampled.
- LS latency in IDLE or YIELD is zero: the access reaches dmem combinationally in the same cycle.
- Grant latency: `sd_request` sampled in cycle N → `sd_granted`=1 in N+1. The first beat may be presented in N+1.
- Release: last beat in cycle M → `sd_granted`=0 and `d_sb`=1 in M+1. A stalled LS access completes in M+1.
- `sd_granted` and `d_sb` are registered. `ls_stall` and `dm_*` are combinational from the state and the inputs.
- Back-to-back bursts: `sd_request` still high in the release cycle starts a re-grant the next cycle. This leaves a one-cycle LS window (IDLE) between bursts.

## Configuration
- Macro: DMEM_ARB_FAIR_EN.
- Defined: YIELD state and MAX_BURST yield logic are present; LS waits at most MAX_BURST+1 cycles during a burst.
- Undefined: there is no YIELD state; SD holds dmem until `sd_done` or abort. MAX_BURST and the counter are unused, and the counter may be optimized away.

## Test plan
- Reset, then `ls_req`=1, `ls_R_nW`=0, addr 0x0010, data 0xA5 → same-cycle `dm_R_nW`=0, `dm_addr`=0x0010, `dm_data`=0xA5; `ls_stall`=0.
- `sd_request` and `ls_req` rise together in IDLE → that LS access is unstalled; `sd_granted`=1 next cycle. Then 4 write beats 0x0100–0x0103, last with `sd_done` → 4 dmem writes, `sd_granted`=0 one cycle after the last beat.
- `ls_req` held during a 4-beat burst → `ls_stall`=1 every GRANT cycle; the access completes in the release cycle.
- Fairness with MAX_BURST=4 and a 10-beat burst, `ls_req` held → YIELD after beat 4 and after beat 8. Each YIELD has `sd_granted`=0 and one unstalled LS access; all 10 SD beats are written. With the macro undefined → no yield, LS stalls for all 10 beats.
- Abort and reset:
  - `sd_request` drops after beat 2 with no `sd_done` → IDLE next cycle.
  - `sd_valid` asserted while `sd_granted`=0 → no write.
  - `rst` mid-burst → all outputs at reset values on the next cycle.
